shift_reg_arbiter: RTL and testbench
====================================

SHIFT_REG_ARBITER -- requirements
Module: shift_reg_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, data width of each request and response; SHALL be at least 16.
REQ-002 Parameter NREQ, default 4, number of requesters; SHALL be 2 to 8.
REQ-003 Parameter SHAMT, default 15, left-rotate amount applied when op=1; SHALL be 1 to WIDTH-1.
REQ-004 clk  input  1  single clock; all state SHALL update on the rising edge only.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  NREQ  per-requester request valid.
REQ-007 req_ready  output  NREQ  per-requester accept strobe.
REQ-008 req_data  input  NREQ*WIDTH  request payload; requester i uses slice [i*WIDTH +: WIDTH].
REQ-009 req_op  input  NREQ  per-requester operation: 0 = pass-through, 1 = rotate-left by SHAMT.
REQ-010 rsp_valid  output  1  result valid.
REQ-011 rsp_ready  input  1  result consumer ready.
REQ-012 rsp_data  output  WIDTH  result data.
REQ-013 rsp_id  output  max(1,$clog2(NREQ))  index of the requester that owns the result.
REQ-014 busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-015 FSM states SHALL be IDLE, EXEC and RESP; reset state SHALL be IDLE.
REQ-016 IDLE, with any req_valid high:
- pick a winner round-robin, searching upward from (last_grant+1) mod NREQ with wrap-around;
- assert req_ready[winner] for that cycle only;
- capture req_data[winner], req_op[winner] and the winner index;
- go to EXEC.
REQ-017 IDLE with no req_valid high SHALL stay in IDLE, with req_ready all zero.
REQ-018 At most one req_ready bit SHALL be high in any cycle, and only when state is IDLE.
REQ-019 A transfer from requester i occurs when req_valid[i] and req_ready[i] are both high; a requester SHALL hold req_valid, data and op stable until that transfer.
REQ-020 EXEC SHALL last exactly one cycle:
- drive the shift-core input with the captured data, and en with the captured op;
- the core registers its result at the end of EXEC;
- go to RESP.
REQ-021 Core function:
- en=0: output equals input;
- en=1: output equals input rotated left by SHAMT, so bit k moves to bit (k+SHAMT) mod WIDTH.
REQ-022 RESP SHALL hold rsp_valid=1, with rsp_data and rsp_id stable, until the cycle rsp_ready=1; in that cycle the FSM SHALL go to IDLE.
REQ-023 rsp_valid SHALL be 0 outside RESP.
REQ-024 last_grant SHALL update to the winner index on each accept; its reset value SHALL be NREQ-1, so requester 0 wins the first contention.
REQ-025 Latency from accept to rsp_valid SHALL be 2 cycles.
REQ-026 Minimum request-to-request spacing SHALL be 3 cycles: accept, EXEC, RESP with rsp_ready high.
REQ-027 A requester that keeps req_valid high SHALL be granted within NREQ grants (starvation-free).
REQ-028 A req_valid change during EXEC or RESP SHALL NOT affect the transaction in flight.

Reset
REQ-029 Reset assertion SHALL, asynchronously and in any state (including mid-EXEC or mid-RESP):
- force state to IDLE;
- clear req_ready, rsp_valid, rsp_data, rsp_id and busy to 0;
- clear the core register to 0;
- set last_grant to NREQ-1.
REQ-030 After reset deassertion, the first accept SHALL occur no earlier than the first rising edge at which rst is high.
REQ-031 A transaction interrupted by reset SHALL be dropped, with no response.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding (IDLE=2'b00, EXEC=2'b01, RESP=2'b10) and the op encoding constants OP_PASS=0 and OP_ROT=1.
REQ-033 The datapath SHALL be a separate sub-module, shift_rot_core (clk, rst, en, data_in, data_out, 1-cycle latency), instantiated once.
REQ-034 The round-robin pick SHALL be combinational logic inside the arbiter, not a separate module.

Verification
REQ-035 Reset with NREQ=4, then only req_valid[2]=1, req_op[2]=0, data 32'hDEADBEEF -> req_ready[2] high 1 cycle; 2 cycles later rsp_valid=1, rsp_data=32'hDEADBEEF, rsp_id=2.
REQ-036 req_op=1, data 32'h00000001, SHAMT=15 -> rsp_data=32'h00008000; data 32'h80000000 -> rsp_data=32'h00004000.
REQ-037 All four req_valid held high, rsp_ready=1 -> grant order 0,1,2,3,0; accepts exactly 3 cycles apart.
REQ-038 rsp_ready held 0 for 5 cycles in RESP -> rsp_valid, rsp_data and rsp_id stable; no req_ready asserted; the pending requester is accepted on the cycle after rsp_ready=1.
REQ-039 rst pulled low in EXEC -> outputs 0 immediately; no response emitted; after release with req_valid[0]=1 and req_valid[3]=1 -> requester 0 granted first.

Source files
------------

// File: rtl/shift_reg_arbiter_pkg.sv
// Shared definitions for the shift/rotate arbiter: FSM state encoding, op codes
// and a helper for sizing the requester-index field.
package shift_reg_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      EXEC = 2'b01,
      RESP = 2'b10
   } state_t;

   localparam logic OP_PASS = 1'b0;
   localparam logic OP_ROT  = 1'b1;

   // Index width never collapses to zero, even for a single requester.
   function automatic int idWidth(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/shift_reg_arbiter_core.sv
// Registered datapath: passes its input through, or rotates it left by SHAMT,
// with one cycle of latency.
module shift_rot_core
   import shift_reg_arbiter_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHAMT = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out
);

   logic [WIDTH-1:0] w_rotated;
   logic [WIDTH-1:0] r_data;

   // Bit k lands on bit (k+SHAMT) mod WIDTH.
   assign w_rotated = (data_in << SHAMT) | (data_in >> (WIDTH - SHAMT));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_data <= '0;
      end else begin
         r_data <= (en == OP_ROT) ? w_rotated : data_in;
      end
   end

   assign data_out = r_data;

endmodule

// File: rtl/shift_reg_arbiter.sv
// Round-robin arbiter feeding a single shared shift/rotate core; one
// transaction in flight at a time, IDLE -> EXEC -> RESP.
module shift_reg_arbiter
   import shift_reg_arbiter_pkg::*;
#(
   parameter  int WIDTH = 32,
   parameter  int NREQ  = 4,
   parameter  int SHAMT = 15,
   localparam int IDW   = idWidth(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_data,
   input  logic [NREQ-1:0]       req_op,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [WIDTH-1:0]      rsp_data,
   output logic [IDW-1:0]        rsp_id,
   output logic                  busy
);

   state_t           r_state;
   state_t           w_nextState;
   logic             w_accept;
   logic             w_anyValid;
   logic [IDW-1:0]   w_winner;
   int               w_dist;
   int               w_bestDist;
   logic [WIDTH-1:0] w_selData;
   logic             w_selOp;
   logic [IDW-1:0]   r_lastGrant;
   logic [IDW-1:0]   r_id;
   logic [WIDTH-1:0] r_data;
   logic             r_op;
   logic [WIDTH-1:0] w_coreOut;

   assign w_anyValid = |req_valid;

   // Winner is the valid requester with the smallest upward distance from last_grant+1.
   always_comb begin
      w_winner   = '0;
      w_bestDist = NREQ;
      w_dist     = 0;
      for (int i = 0; i < NREQ; i++) begin
         w_dist = (i + NREQ - 1 - int'(r_lastGrant)) % NREQ;
         if (req_valid[i] && (w_dist < w_bestDist)) begin
            w_bestDist = w_dist;
            w_winner   = IDW'(i);
         end
      end
   end

   always_comb begin
      w_selData = '0;
      w_selOp   = OP_PASS;
      for (int i = 0; i < NREQ; i++) begin
         if (IDW'(i) == w_winner) begin
            w_selData = req_data[i*WIDTH +: WIDTH];
            w_selOp   = req_op[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Accept is gated by rst so no strobe leaks out while reset is held.
   always_comb begin
      w_nextState = r_state;
      w_accept    = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_anyValid && rst) begin
               w_accept    = 1'b1;
               w_nextState = EXEC;
            end
         end
         EXEC: w_nextState = RESP;
         RESP: begin
            if (rsp_ready) begin
               w_nextState = IDLE;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_data      <= '0;
         r_op        <= OP_PASS;
         r_id        <= '0;
         r_lastGrant <= IDW'(NREQ - 1);
      end else if (w_accept) begin
         r_data      <= w_selData;
         r_op        <= w_selOp;
         r_id        <= w_winner;
         r_lastGrant <= w_winner;
      end
   end

   shift_rot_core #(
      .WIDTH (WIDTH),
      .SHAMT (SHAMT)
   ) u_core (
      .clk      (clk),
      .rst      (rst),
      .en       (r_op),
      .data_in  (r_data),
      .data_out (w_coreOut)
   );

   assign req_ready = w_accept ? (NREQ'(1) << w_winner) : '0;
   assign rsp_valid = (r_state == RESP);
   assign rsp_data  = w_coreOut;
   assign rsp_id    = r_id;
   assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_shift_reg_arbiter.sv
// Scoreboard bench for shift_reg_arbiter: expected responses are queued at
// accept time and checked when the response handshake completes.
module tb_shift_reg_arbiter;

   localparam int WIDTH = 32;
   localparam int NREQ  = 4;
   localparam int SHAMT = 15;

   typedef struct {
      logic [31:0] data;
      logic [1:0]  id;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   reqValid;
   logic [3:0]   reqReady;
   logic [127:0] reqData;
   logic [3:0]   reqOp;
   logic         rspValid;
   logic         rspReady;
   logic [31:0]  rspData;
   logic [1:0]   rspId;
   logic         busy;

   int   compared   = 0;
   int   mismatched = 0;
   exp_t sbQ[$];

   always #5 clk = ~clk;

   shift_reg_arbiter #(
      .WIDTH (WIDTH),
      .NREQ  (NREQ),
      .SHAMT (SHAMT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (reqValid),
      .req_ready (reqReady),
      .req_data  (reqData),
      .req_op    (reqOp),
      .rsp_valid (rspValid),
      .rsp_ready (rspReady),
      .rsp_data  (rspData),
      .rsp_id    (rspId),
      .busy      (busy)
   );

   // Independent rotate model: take a 32-bit window out of the doubled word.
   function automatic logic [31:0] rotl15(input logic [31:0] x);
      logic [63:0] d;
      d = {x, x};
      return d[48:17];
   endfunction

   task automatic setReq(input int i, input logic v, input logic op, input logic [31:0] d);
      reqValid[i]           = v;
      reqOp[i]              = op;
      reqData[i*32 +: 32]   = d;
   endtask

   task automatic test_reset();
      rst = 1'b0; reqValid = '0; reqOp = '0; reqData = '0; rspReady = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      compared++; if (reqReady !== 4'b0000) begin mismatched++; $display("[TB] FAIL reset_ready: got %b want 0000", reqReady); end
      compared++; if (rspValid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_rsp_valid: got %b want 0", rspValid); end
      compared++; if (rspData !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_rsp_data: got %h want 00000000", rspData); end
      compared++; if (rspId !== 2'd0) begin mismatched++; $display("[TB] FAIL reset_rsp_id: got %0d want 0", rspId); end
      compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
      reqValid = 4'b0001;
      #1;
      compared++; if (reqReady !== 4'b0000) begin mismatched++; $display("[TB] FAIL reset_gated_ready: got %b want 0000", reqReady); end
      @(negedge clk);
      rst = 1'b1; reqValid = '0;
      #1;
      compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL post_reset_busy: got %b want 0", busy); end
   endtask

   task automatic test_pass_through();
      exp_t e;
      @(negedge clk);
      rspReady = 1'b1;
      setReq(2, 1'b1, 1'b0, 32'hDEADBEEF);
      #1;
      compared++; if (reqReady !== 4'b0100) begin mismatched++; $display("[TB] FAIL pass_ready: got %b want 0100", reqReady); end
      sbQ.push_back('{32'hDEADBEEF, 2'd2});
      @(negedge clk);
      reqValid = '0;
      #1;
      compared++; if ({reqReady, rspValid, busy} !== 6'b0000_0_1) begin mismatched++; $display("[TB] FAIL pass_exec: got ready=%b valid=%b busy=%b want 0000/0/1", reqReady, rspValid, busy); end
      @(negedge clk);
      #1;
      compared++; if (rspValid !== 1'b1) begin mismatched++; $display("[TB] FAIL pass_latency: got valid=%b want 1", rspValid); end
      if (sbQ.size() > 0) begin
         e = sbQ.pop_front();
         compared++; if (rspData !== e.data || rspId !== e.id) begin mismatched++; $display("[TB] FAIL pass_rsp: got %h/%0d want %h/%0d", rspData, rspId, e.data, e.id); end
      end
      @(negedge clk);
      #1;
      compared++; if (rspValid !== 1'b0 || busy !== 1'b0) begin mismatched++; $display("[TB] FAIL pass_return_idle: got valid=%b busy=%b want 0/0", rspValid, busy); end
   endtask

   task automatic test_rotate();
      logic [31:0] vec[4];
      exp_t        e;
      logic        accepted;
      logic        got;
      vec[0] = 32'h00000001; vec[1] = 32'h80000000; vec[2] = 32'hA5A50F0F; vec[3] = $urandom;
      rspReady = 1'b1;
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         setReq(1, 1'b1, 1'b1, vec[j]);
         accepted = 1'b0;
         got      = 1'b0;
         for (int c = 0; c < 8 && !got; c++) begin
            #1;
            if (reqReady[1] && !accepted) begin
               accepted = 1'b1;
               sbQ.push_back('{rotl15(vec[j]), 2'd1});
            end
            if (rspValid && rspReady) begin
               got = 1'b1;
               compared++;
               if (sbQ.size() == 0) begin
                  mismatched++; $display("[TB] FAIL rot_spurious: got %h want no response", rspData);
               end else begin
                  e = sbQ.pop_front();
                  if (rspData !== e.data || rspId !== e.id) begin mismatched++; $display("[TB] FAIL rot_rsp[%0d]: got %h/%0d want %h/%0d", j, rspData, rspId, e.data, e.id); end
               end
            end
            @(negedge clk);
            if (accepted) reqValid[1] = 1'b0;
         end
         compared++; if (!got) begin mismatched++; $display("[TB] FAIL rot_timeout[%0d]: got no response want one", j); end
      end
   endtask

   task automatic test_round_robin();
      logic [31:0] d[4];
      int          order[5];
      int          cyc[5];
      int          nGrants;
      int          idx;
      exp_t        e;
      @(negedge clk); rst = 1'b0;
      @(negedge clk); rst = 1'b1;
      rspReady = 1'b1;
      for (int i = 0; i < 4; i++) begin
         d[i] = 32'hC0DE0000 + i;
         setReq(i, 1'b1, (i == 3), d[i]);
      end
      nGrants = 0;
      for (int c = 0; c < 40 && (nGrants < 5 || sbQ.size() > 0); c++) begin
         #1;
         if (reqReady != 4'b0000) begin
            compared++; if (!$onehot(reqReady)) begin mismatched++; $display("[TB] FAIL rr_onehot: got %b want one-hot", reqReady); end
            idx = 0;
            for (int k = 0; k < 4; k++) if (reqReady[k]) idx = k;
            if (nGrants < 5) begin
               order[nGrants] = idx;
               cyc[nGrants]   = c;
               sbQ.push_back('{(reqOp[idx] ? rotl15(d[idx]) : d[idx]), 2'(idx)});
               nGrants++;
            end
         end
         if (rspValid && rspReady && sbQ.size() > 0) begin
            e = sbQ.pop_front();
            compared++; if (rspData !== e.data || rspId !== e.id) begin mismatched++; $display("[TB] FAIL rr_rsp: got %h/%0d want %h/%0d", rspData, rspId, e.data, e.id); end
         end
         @(negedge clk);
         if (nGrants == 5) reqValid = '0;
      end
      compared++; if (nGrants != 5) begin mismatched++; $display("[TB] FAIL rr_grant_count: got %0d want 5", nGrants); end
      for (int k = 0; k < nGrants; k++) begin
         compared++; if (order[k] != k % 4) begin mismatched++; $display("[TB] FAIL rr_order[%0d]: got %0d want %0d", k, order[k], k % 4); end
         if (k > 0) begin
            compared++; if (cyc[k] - cyc[k-1] != 3) begin mismatched++; $display("[TB] FAIL rr_spacing[%0d]: got %0d want 3", k, cyc[k] - cyc[k-1]); end
         end
      end
      compared++; if (sbQ.size() != 0) begin mismatched++; $display("[TB] FAIL rr_drain: got %0d pending want 0", sbQ.size()); end
      sbQ.delete();
   endtask

   task automatic test_backpressure();
      logic [31:0] x;
      logic [31:0] y;
      exp_t        e;
      x = 32'h12345678;
      y = 32'h0BADF00D;
      @(negedge clk);
      rspReady = 1'b0;
      setReq(3, 1'b1, 1'b1, x);
      #1;
      compared++; if (reqReady !== 4'b1000) begin mismatched++; $display("[TB] FAIL bp_ready: got %b want 1000", reqReady); end
      sbQ.push_back('{rotl15(x), 2'd3});
      @(negedge clk);
      reqValid = '0;
      setReq(1, 1'b1, 1'b0, y);
      #1;
      compared++; if (reqReady !== 4'b0000 || rspValid !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_exec: got ready=%b valid=%b want 0000/0", reqReady, rspValid); end
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         #1;
         compared++;
         if (rspValid !== 1'b1 || rspData !== rotl15(x) || rspId !== 2'd3 || reqReady !== 4'b0000) begin
            mismatched++; $display("[TB] FAIL bp_stall[%0d]: got v=%b d=%h id=%0d rdy=%b want 1/%h/3/0000", k, rspValid, rspData, rspId, reqReady, rotl15(x));
         end
         @(negedge clk);
      end
      rspReady = 1'b1;
      #1;
      compared++; if (rspValid !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_release_valid: got %b want 1", rspValid); end
      if (sbQ.size() > 0) begin
         e = sbQ.pop_front();
         compared++; if (rspData !== e.data || rspId !== e.id) begin mismatched++; $display("[TB] FAIL bp_rsp: got %h/%0d want %h/%0d", rspData, rspId, e.data, e.id); end
      end
      @(negedge clk);
      #1;
      compared++; if (reqReady !== 4'b0010) begin mismatched++; $display("[TB] FAIL bp_pending_accept: got %b want 0010", reqReady); end
      sbQ.push_back('{y, 2'd1});
      @(negedge clk);
      reqValid = '0;
      for (int c = 0; c < 8 && sbQ.size() > 0; c++) begin
         #1;
         if (rspValid && rspReady) begin
            e = sbQ.pop_front();
            compared++; if (rspData !== e.data || rspId !== e.id) begin mismatched++; $display("[TB] FAIL bp_rsp2: got %h/%0d want %h/%0d", rspData, rspId, e.data, e.id); end
         end
         @(negedge clk);
      end
      compared++; if (sbQ.size() != 0) begin mismatched++; $display("[TB] FAIL bp_drain: got %0d pending want 0", sbQ.size()); end
      sbQ.delete();
   endtask

   task automatic test_reset_mid_exec();
      exp_t e;
      int   nRsp;
      @(negedge clk);
      rspReady = 1'b1;
      setReq(2, 1'b1, 1'b1, 32'hFACE0001);
      #1;
      compared++; if (reqReady !== 4'b0100) begin mismatched++; $display("[TB] FAIL rst_pre_ready: got %b want 0100", reqReady); end
      @(negedge clk);
      reqValid = '0;
      #1;
      compared++; if (busy !== 1'b1) begin mismatched++; $display("[TB] FAIL rst_in_exec: got busy=%b want 1", busy); end
      #2;
      rst = 1'b0;
      #1;
      compared++;
      if ({reqReady, rspValid, rspData, rspId, busy} !== 40'h0) begin
         mismatched++; $display("[TB] FAIL rst_async_clear: got rdy=%b v=%b d=%h id=%0d busy=%b want all 0", reqReady, rspValid, rspData, rspId, busy);
      end
      setReq(0, 1'b1, 1'b0, 32'h0000AAAA);
      setReq(3, 1'b1, 1'b0, 32'h0000BBBB);
      @(negedge clk);
      #1;
      compared++; if (reqReady !== 4'b0000 || rspValid !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_held: got rdy=%b v=%b want 0000/0", reqReady, rspValid); end
      @(negedge clk);
      rst = 1'b1;
      #1;
      compared++; if (reqReady !== 4'b0001) begin mismatched++; $display("[TB] FAIL rst_first_grant: got %b want 0001", reqReady); end
      sbQ.push_back('{32'h0000AAAA, 2'd0});
      @(negedge clk);
      reqValid = '0;
      nRsp = 0;
      for (int c = 0; c < 10; c++) begin
         #1;
         if (rspValid && rspReady) begin
            nRsp++;
            compared++;
            if (sbQ.size() == 0) begin
               mismatched++; $display("[TB] FAIL rst_spurious_rsp: got %h/%0d want none", rspData, rspId);
            end else begin
               e = sbQ.pop_front();
               if (rspData !== e.data || rspId !== e.id) begin mismatched++; $display("[TB] FAIL rst_rsp: got %h/%0d want %h/%0d", rspData, rspId, e.data, e.id); end
            end
         end
         @(negedge clk);
      end
      compared++; if (nRsp != 1) begin mismatched++; $display("[TB] FAIL rst_rsp_count: got %0d want 1", nRsp); end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout want completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_pass_through();
      test_rotate();
      test_round_robin();
      test_backpressure();
      test_reset_mid_exec();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
